// File: rtl/sobel_grad_stream.sv
// Streaming 3x3 Sobel gradient engine: one pixel in, one magnitude out, two-stage pipeline.
// Two line buffers feed a 3x3 window; the border region is forced to zero.
module sobel_grad_stream #(
   parameter int PIX_W  = 8,
   parameter int IM_LEN = 520,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 2,
   localparam int LW    = $clog2(IM_LEN + 1)
) (
   input  logic             clk,
   input  logic             hres_n,
   input  logic             hclr,
   input  logic [LW-1:0]    line_len,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pix,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_mag,
   output logic             out_eol
);

   localparam int GW = PIX_W + 4;
   localparam int AW = PIX_W + 3;
   localparam int SW = PIX_W + 4;

   logic [LW-1:0]    col, len_reg;
   logic [1:0]       row;

   logic             accept, sof_acc, len_ok, last;
   logic [LW-1:0]    len_new, cur_len, cur_col;
   logic [1:0]       cur_row;
   logic             border;

   logic [PIX_W-1:0] lb1 [IM_LEN];
   logic [PIX_W-1:0] lb2 [IM_LEN];
   logic [PIX_W-1:0] a1, a2;

   logic [PIX_W-1:0] p00, p10, p20, p01, p11, p21;

   logic signed [GW-1:0] t00, t10, t20, t01, t21, t02, t12, t22;
   logic signed [GW-1:0] gx, gy;

   logic                 s1_valid, s1_eol;
   logic signed [GW-1:0] s1_gx, s1_gy;
   logic [1:0]           s1_mode;

   logic [AW-1:0]    ax, ay;
   logic [SW-1:0]    sel;
   logic [31:0]      shv;
   logic [OUT_W-1:0] mag;

   assign accept  = in_valid & ~hclr;
   assign sof_acc = accept & in_sof;
   assign len_ok  = (line_len >= LW'(3)) && (line_len <= LW'(IM_LEN));
   assign len_new = len_ok ? line_len : LW'(IM_LEN);

   // in_sof re-anchors the current pixel at (0,0) and overrides any wrap
   assign cur_len = sof_acc ? len_new : len_reg;
   assign cur_col = in_sof ? '0 : col;
   assign cur_row = in_sof ? '0 : row;
   assign last    = (cur_col == cur_len - LW'(1));
   assign border  = (cur_row < 2'd2) || (cur_col < LW'(2));

   always_ff @(posedge clk or negedge hres_n) begin
      if (!hres_n) begin
         col     <= '0;
         row     <= '0;
         len_reg <= LW'(IM_LEN);
      end else if (hclr) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (sof_acc)
            len_reg <= len_new;
         if (last) begin
            col <= '0;
            row <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
         end else begin
            col <= cur_col + LW'(1);
            row <= cur_row;
         end
      end
   end

   assign a1 = lb1[cur_col];
   assign a2 = lb2[cur_col];

   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[cur_col] <= in_pix;
         lb2[cur_col] <= a1;
         p00 <= p01;
         p10 <= p11;
         p20 <= p21;
         p01 <= a2;
         p11 <= a1;
         p21 <= in_pix;
      end
   end

   always_comb begin
      t00 = GW'(p00);
      t10 = GW'(p10);
      t20 = GW'(p20);
      t01 = GW'(p01);
      t21 = GW'(p21);
      t02 = GW'(a2);
      t12 = GW'(a1);
      t22 = GW'(in_pix);
      gx  = (t02 + (t12 <<< 1) + t22) - (t00 + (t10 <<< 1) + t20);
      gy  = (t20 + (t21 <<< 1) + t22) - (t00 + (t01 <<< 1) + t02);
   end

   always_ff @(posedge clk or negedge hres_n) begin
      if (!hres_n) begin
         s1_valid <= 1'b0;
         s1_eol   <= 1'b0;
         s1_gx    <= '0;
         s1_gy    <= '0;
         s1_mode  <= '0;
      end else if (hclr) begin
         s1_valid <= 1'b0;
         s1_eol   <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_gx   <= border ? '0 : gx;
            s1_gy   <= border ? '0 : gy;
            s1_mode <= mode;
            s1_eol  <= last;
         end
      end
   end

   always_comb begin
      ax = s1_gx[GW-1] ? AW'(-s1_gx) : AW'(s1_gx);
      ay = s1_gy[GW-1] ? AW'(-s1_gy) : AW'(s1_gy);
      case (s1_mode)
         2'd0:    sel = {1'b0, ay};
         2'd1:    sel = {1'b0, ax};
         2'd2:    sel = {1'b0, ax} + {1'b0, ay};
         default: sel = (ax > ay) ? {1'b0, ax} : {1'b0, ay};
      endcase
      shv = 32'(sel) >> SHIFT;
      mag = (shv > 32'((2 ** OUT_W) - 1)) ? '1 : shv[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge hres_n) begin
      if (!hres_n) begin
         out_valid <= 1'b0;
         out_mag   <= '0;
         out_eol   <= 1'b0;
      end else if (hclr) begin
         out_valid <= 1'b0;
         out_mag   <= '0;
         out_eol   <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         out_mag   <= s1_valid ? mag : '0;
         out_eol   <= s1_valid & s1_eol;
      end
   end

endmodule

// File: tb/tb_sobel_grad_stream.sv
// Bench for sobel_grad_stream: directed frames plus random pixels, checked against an image-level model.
module tb_sobel_grad_stream;

   localparam int PIX_W  = 8;
   localparam int IM_LEN = 520;
   localparam int OUT_W  = 8;
   localparam int SHIFT  = 2;
   localparam int LW     = $clog2(IM_LEN + 1);

   logic             clk = 1'b0;
   logic             hres_n;
   logic             hclr;
   logic [LW-1:0]    line_len;
   logic [1:0]       mode;
   logic             in_valid;
   logic             in_sof;
   logic [PIX_W-1:0] in_pix;
   logic             out_valid;
   logic [OUT_W-1:0] out_mag;
   logic             out_eol;

   sobel_grad_stream #(
      .PIX_W(PIX_W), .IM_LEN(IM_LEN), .OUT_W(OUT_W), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .hres_n(hres_n), .hclr(hclr), .line_len(line_len), .mode(mode),
      .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
      .out_valid(out_valid), .out_mag(out_mag), .out_eol(out_eol)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;
   int n_out, n_eol, max_mag;

   // reference image model: rows kept modulo 32, full line width
   int img [32][IM_LEN];
   int m_r, m_c, m_len;
   int q_mag [$];
   int q_eol [$];
   bit prev;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int px(int r, int c);
      return img[r % 32][c];
   endfunction

   function automatic int ref_mag(int gx, int gy, int md);
      int ax, ay, v;
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      case (md)
         0:       v = ay;
         1:       v = ax;
         2:       v = ax + ay;
         default: v = (ax > ay) ? ax : ay;
      endcase
      v = v >> SHIFT;
      return (v > 255) ? 255 : v;
   endfunction

   task automatic model_accept(int pix, bit sof, int md);
      int gx, gy, r, c;
      if (sof) begin
         m_r = 0;
         m_c = 0;
         m_len = (int'(line_len) < 3 || int'(line_len) > IM_LEN) ? IM_LEN : int'(line_len);
      end
      r = m_r;
      c = m_c;
      img[r % 32][c] = pix;
      if (r < 2 || c < 2) begin
         gx = 0;
         gy = 0;
      end else begin
         gx = (px(r-2, c) + 2*px(r-1, c) + px(r, c)) - (px(r-2, c-2) + 2*px(r-1, c-2) + px(r, c-2));
         gy = (px(r, c-2) + 2*px(r, c-1) + px(r, c)) - (px(r-2, c-2) + 2*px(r-2, c-1) + px(r-2, c));
      end
      q_mag.push_back(ref_mag(gx, gy, md));
      q_eol.push_back((c == m_len - 1) ? 1 : 0);
      if (c == m_len - 1) begin
         m_c = 0;
         m_r = m_r + 1;
      end else begin
         m_c = m_c + 1;
      end
   endtask

   task automatic step(bit v, bit sof, int pix, int md, bit clr);
      int em, ee;
      @(negedge clk);
      in_valid = v;
      in_sof   = sof;
      in_pix   = PIX_W'(pix);
      mode     = 2'(md);
      hclr     = clr;
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), clr ? 32'd0 : 32'(prev));
      if (out_valid === 1'b1) begin
         n_out++;
         if (out_eol === 1'b1) n_eol++;
         if (int'(out_mag) > max_mag) max_mag = int'(out_mag);
      end
      if (!clr && prev) begin
         if (q_mag.size() > 0) begin
            em = q_mag.pop_front();
            ee = q_eol.pop_front();
            chk("out_mag", 32'(out_mag), 32'(em));
            chk("out_eol", 32'(out_eol), 32'(ee));
         end else begin
            chk("model_queue_empty", 32'(q_mag.size()), 32'd1);
         end
      end
      if (clr) begin
         q_mag.delete();
         q_eol.delete();
         prev = 1'b0;
         m_r = 0;
         m_c = 0;
      end else begin
         prev = v;
         if (v) model_accept(pix, sof, md);
      end
   endtask

   // kind: 0 const 100, 1 column ramp, 2 horizontal step, 3 diagonal ramp, 4 random; md<0 = random mode
   task automatic frame(int kind, int rows, int cols, int md, int gap);
      int pix, m;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            while (gap > 0 && $urandom_range(99) < gap) step(1'b0, 1'b0, 0, 0, 1'b0);
            case (kind)
               0:       pix = 100;
               1:       pix = c * 10;
               2:       pix = (r >= 4) ? 255 : 0;
               3:       pix = (r + c) * 16;
               default: pix = $urandom_range(255);
            endcase
            m = (md < 0) ? $urandom_range(3) : md;
            step(1'b1, (r == 0 && c == 0), pix, m, 1'b0);
         end
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic clear_stats();
      n_out = 0;
      n_eol = 0;
      max_mag = 0;
   endtask

   initial begin
      hres_n = 1'b0;
      hclr = 1'b0;
      line_len = LW'(8);
      mode = 2'd0;
      in_valid = 1'b0;
      in_sof = 1'b0;
      in_pix = '0;
      m_r = 0;
      m_c = 0;
      m_len = IM_LEN;
      prev = 1'b0;
      clear_stats();
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_mag", 32'(out_mag), 32'd0);
      chk("rst_out_eol", 32'(out_eol), 32'd0);
      hres_n = 1'b1;

      // 1: constant frame
      clear_stats();
      frame(0, 8, 8, 2, 0);
      chk("t1_count", 32'(n_out), 32'd64);
      chk("t1_eol", 32'(n_eol), 32'd8);
      chk("t1_max", 32'(max_mag), 32'd0);

      // 2: column ramp
      clear_stats();
      frame(1, 8, 8, 1, 0);
      chk("t2_gx_max", 32'(max_mag), 32'd20);
      clear_stats();
      frame(1, 8, 8, 0, 0);
      chk("t2_gy_max", 32'(max_mag), 32'd0);

      // 3: horizontal step
      clear_stats();
      frame(2, 8, 8, 0, 0);
      chk("t3_gy_max", 32'(max_mag), 32'd255);
      clear_stats();
      frame(2, 8, 8, 2, 0);
      chk("t3_sum_max", 32'(max_mag), 32'd255);

      // 4: diagonal ramp
      clear_stats();
      frame(3, 8, 8, 2, 0);
      chk("t4_sum_max", 32'(max_mag), 32'd64);
      clear_stats();
      frame(3, 8, 8, 3, 0);
      chk("t4_max_max", 32'(max_mag), 32'd32);

      // 5: ramp with input gaps
      clear_stats();
      frame(1, 8, 8, 1, 50);
      chk("t5_count", 32'(n_out), 32'd64);
      chk("t5_max", 32'(max_mag), 32'd20);

      // line length boundaries: 3 is legal, 2 falls back to IM_LEN
      line_len = LW'(3);
      clear_stats();
      frame(4, 5, 3, -1, 0);
      chk("len3_eol", 32'(n_eol), 32'd5);
      line_len = LW'(2);
      clear_stats();
      frame(4, 1, 12, -1, 0);
      chk("len2_eol", 32'(n_eol), 32'd0);
      line_len = LW'(8);
      frame(4, 8, 8, -1, 20);

      // 6: mid-line sof, hclr, async reset
      line_len = LW'(16);
      for (int i = 0; i < 3*16 + 5; i++)
         step(1'b1, (i == 0), $urandom_range(255), $urandom_range(3), 1'b0);
      step(1'b1, 1'b1, $urandom_range(255), $urandom_range(3), 1'b0);
      for (int i = 0; i < 40; i++)
         step(1'b1, 1'b0, $urandom_range(255), $urandom_range(3), 1'b0);
      step(1'b1, 1'b0, $urandom_range(255), $urandom_range(3), 1'b1);
      for (int i = 0; i < 40; i++)
         step(1'b1, 1'b0, $urandom_range(255), $urandom_range(3), 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof = 1'b0;
      in_pix = PIX_W'($urandom_range(255));
      hclr = 1'b0;
      #2 hres_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_mag", 32'(out_mag), 32'd0);
      chk("arst_out_eol", 32'(out_eol), 32'd0);
      q_mag.delete();
      q_eol.delete();
      prev = 1'b0;
      m_r = 0;
      m_c = 0;
      m_len = IM_LEN;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      hres_n = 1'b1;
      clear_stats();
      for (int i = 0; i < 30; i++)
         step(1'b1, 1'b0, $urandom_range(255), $urandom_range(3), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
      chk("post_rst_count", 32'(n_out), 32'd30);
      chk("post_rst_row0_max", 32'(max_mag), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
